// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: blocking load/store unit between the ALU and data memory.
// It handles one RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW access at a time. It steers
// byte lanes, checks alignment, extends loads and aborts stuck accesses.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    // core request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    // data memory port
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    // completion side
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [1:0]  ERR_OK    = 2'b00;
    localparam logic [1:0]  ERR_ALIGN = 2'b01;
    localparam logic [1:0]  ERR_TMO   = 2'b10;
    localparam logic [1:0]  ERR_ILL   = 2'b11;
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t      state;
    logic        stale;     // a timed-out WAIT still owes us one mem_rvalid
    logic [31:0] tcnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic [1:0]  dec_err;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] tcnt_inc;
    logic        tmo_hit;

    assign req_ready = (state == IDLE) && !stale;
    assign mem_valid = (state == REQ);
    assign rsp_valid = (state == RESP);

    assign tcnt_inc = tcnt + 32'd1;
    assign tmo_hit  = (TMO_LIMIT != 32'd0) && (tcnt_inc == TMO_LIMIT);

    // Decode the incoming request: lane enables, replicated store data, errors.
    // An illegal encoding takes priority over a misaligned one.
    always_comb begin
        dec_err   = ERR_OK;
        dec_be    = 4'b0000;
        dec_wdata = req_wdata;
        case (req_funct3)
            3'b000, 3'b100: begin
                dec_be    = 4'b0001 << req_addr[1:0];
                dec_wdata = {4{req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                dec_be    = 4'b0011 << req_addr[1:0];
                dec_wdata = {2{req_wdata[15:0]}};
                if (req_addr[0]) dec_err = ERR_ALIGN;
            end
            3'b010: begin
                dec_be = 4'b1111;
                if (req_addr[1:0] != 2'b00) dec_err = ERR_ALIGN;
            end
            default: dec_err = ERR_ILL;
        endcase
        // unsigned variants have no store counterpart
        if (req_we && req_funct3[2]) dec_err = ERR_ILL;
    end

    // Bring the addressed bytes down to bit 0, then sign- or zero-extend them.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Main FSM with registered memory fields, response, timeout counter and stale flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stale     <= 1'b0;
            tcnt      <= 32'd0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            mem_addr  <= 32'd0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'd0;
            rsp_data  <= 32'd0;
            rsp_err   <= ERR_OK;
        end else begin
            // A late response to an aborted access is swallowed here.
            if (stale && mem_rvalid) stale <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        rsp_data <= 32'd0;
                        rsp_err  <= dec_err;
                        if (dec_err != ERR_OK) begin
                            state <= RESP;
                        end else begin
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_we    <= req_we;
                            mem_be    <= dec_be;
                            mem_wdata <= dec_wdata;
                            f3_q      <= req_funct3;
                            off_q     <= req_addr[1:0];
                            tcnt      <= 32'd0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    tcnt <= tcnt_inc;
                    // the handshake beats a coincident timeout
                    if (mem_ready) begin
                        state <= WAIT;
                    end else if (tmo_hit) begin
                        rsp_err <= ERR_TMO;
                        state   <= RESP;
                    end
                end
                WAIT: begin
                    tcnt <= tcnt_inc;
                    if (mem_rvalid) begin
                        rsp_data <= mem_we ? 32'd0 : load_data;
                        state    <= RESP;
                    end else if (tmo_hit) begin
                        // memory still owes us a response; drain it before the next access
                        rsp_err <= ERR_TMO;
                        stale   <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed testbench for lsu_mem_stage: scoreboarded accesses, error paths,
// backpressure, timeout with stale drain, and reset in the middle of an access.
module tb_lsu_mem_stage;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    lsu_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence below.
    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the DUT response against the oldest scoreboard entry.
    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "/sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "/rsp_data"}, rsp_data, e.data);
            chk({tag, "/rsp_err"}, 32'(rsp_err), 32'(e.err));
        end
    endtask

    task automatic check_mem(input string tag, input logic [31:0] addr, input logic we,
                             input logic [3:0] be, input logic [31:0] wd);
        chk({tag, "/mem_valid"}, 32'(mem_valid), 32'd1);
        chk({tag, "/mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, "/mem_we"}, 32'(mem_we), 32'(we));
        chk({tag, "/mem_be"}, 32'(mem_be), 32'(be));
        chk({tag, "/mem_wdata"}, mem_wdata, wd);
    endtask

    // One complete access with fixed-latency expectations. rdy_dly is the
    // number of cycles mem_ready is held low while the request is presented.
    task automatic access(input string tag, input logic [31:0] addr, input logic we,
                          input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] rd,
                          input int rdy_dly, input logic [31:0] exp_data, input logic [1:0] exp_err,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        exp_t e;
        e.data = exp_data;
        e.err  = exp_err;
        sb.push_back(e);
        chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_we     = we;
        req_funct3 = f3;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (exp_err != 2'b00) begin
            chk({tag, "/no_mem"}, 32'(mem_valid), 32'd0);
        end else begin
            check_mem(tag, addr, we, exp_be, exp_wd);
            for (int i = 0; i < rdy_dly; i++) begin
                tick();
                check_mem({tag, "/hold"}, addr, we, exp_be, exp_wd);
            end
            mem_ready = 1'b1;
            tick();
            mem_ready  = 1'b0;
            chk({tag, "/wait_memv"}, 32'(mem_valid), 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        pop_check(tag);
        tick();
        chk({tag, "/one_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, "/ready_again"}, 32'(req_ready), 32'd1);
    endtask

    // Bounded wait for rsp_valid; returns cycles spent.
    task automatic wait_rsp(input int start, input int bound, output int n);
        n = start;
        while (!rsp_valid && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        exp_t e;
        int   n;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_wdata  = 32'd0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        #12;
        chk("reset/req_ready", 32'(req_ready), 32'd1);
        chk("reset/mem_valid", 32'(mem_valid), 32'd0);
        chk("reset/mem_we", 32'(mem_we), 32'd0);
        chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset/mem_addr", mem_addr, 32'd0);
        chk("reset/mem_be", 32'(mem_be), 32'd0);
        chk("reset/mem_wdata", mem_wdata, 32'd0);
        chk("reset/rsp_data", rsp_data, 32'd0);
        chk("reset/rsp_err", 32'(rsp_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // loads with extension
        access("lb",  32'h1003, 1'b0, 3'b000, 32'd0, 32'h80AA_BBCC, 0, 32'hFFFF_FF80, 2'b00, 4'b1000, 32'd0);
        access("lbu", 32'h1003, 1'b0, 3'b100, 32'd0, 32'h80AA_BBCC, 0, 32'h0000_0080, 2'b00, 4'b1000, 32'd0);
        access("lhu", 32'h0000, 1'b0, 3'b101, 32'd0, 32'h1234_F00F, 0, 32'h0000_F00F, 2'b00, 4'b0011, 32'd0);
        access("lw",  32'h0020, 1'b0, 3'b010, 32'd0, 32'h1234_5678, 0, 32'h1234_5678, 2'b00, 4'b1111, 32'd0);
        // stores
        access("sh",  32'h2002, 1'b1, 3'b001, 32'h1234_ABCD, 32'h5555_5555, 0, 32'd0, 2'b00, 4'b1100, 32'hABCD_ABCD);
        access("sb",  32'h7001, 1'b1, 3'b000, 32'h0000_00A5, 32'h5555_5555, 0, 32'd0, 2'b00, 4'b0010, 32'hA5A5_A5A5);
        access("sw",  32'h0010, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'h5555_5555, 0, 32'd0, 2'b00, 4'b1111, 32'hDEAD_BEEF);
        // error paths
        access("lw_mis", 32'h3001, 1'b0, 3'b010, 32'd0, 32'd0, 0, 32'd0, 2'b01, 4'b0000, 32'd0);
        access("lh_mis", 32'h3005, 1'b0, 3'b001, 32'd0, 32'd0, 0, 32'd0, 2'b01, 4'b0000, 32'd0);
        access("f3_011", 32'h3000, 1'b0, 3'b011, 32'd0, 32'd0, 0, 32'd0, 2'b11, 4'b0000, 32'd0);
        access("sb_100", 32'h3000, 1'b1, 3'b100, 32'd0, 32'd0, 0, 32'd0, 2'b11, 4'b0000, 32'd0);
        // backpressure: mem_ready low for 5 cycles
        access("lh_bp", 32'h1002, 1'b0, 3'b001, 32'd0, 32'h8001_1234, 5, 32'hFFFF_8001, 2'b00, 4'b1100, 32'd0);

        // timeout in WAIT, then stale drain
        e.data = 32'd0;
        e.err  = 2'b10;
        sb.push_back(e);
        req_valid = 1'b1; req_addr = 32'h4000; req_we = 1'b0; req_funct3 = 3'b010;
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        wait_rsp(2, 40, n);
        chk("tmo_wait/latency", 32'(n), 32'(TMO + 1));
        pop_check("tmo_wait");
        tick();
        chk("stale/ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1; req_addr = 32'h4100; req_funct3 = 3'b010;
        tick();
        tick();
        req_valid = 1'b0;
        chk("stale/no_accept", 32'(mem_valid), 32'd0);
        chk("stale/no_rsp", 32'(rsp_valid), 32'd0);
        chk("stale/still", 32'(req_ready), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk("stale/cleared", 32'(req_ready), 32'd1);
        chk("stale/dropped", 32'(rsp_valid), 32'd0);

        // timeout in REQ leaves no stale flag
        e.data = 32'd0;
        e.err  = 2'b10;
        sb.push_back(e);
        req_valid = 1'b1; req_addr = 32'h5000; req_we = 1'b1; req_funct3 = 3'b010; req_wdata = 32'h1111_2222;
        tick();
        req_valid = 1'b0;
        wait_rsp(1, 40, n);
        chk("tmo_req/latency", 32'(n), 32'(TMO + 1));
        pop_check("tmo_req");
        tick();
        chk("tmo_req/ready", 32'(req_ready), 32'd1);

        // reset while in WAIT
        req_valid = 1'b1; req_addr = 32'h6004; req_we = 1'b0; req_funct3 = 3'b010;
        tick();
        req_valid = 1'b0;
        chk("rst_mid/memv", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid/mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mid/mem_addr", mem_addr, 32'd0);
        chk("rst_mid/mem_be", 32'(mem_be), 32'd0);
        chk("rst_mid/req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid/rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        chk("rst_mid/no_rsp0", 32'(rsp_valid), 32'd0);
        tick();
        chk("rst_mid/no_rsp1", 32'(rsp_valid), 32'd0);
        access("lw_after_rst", 32'h0040, 1'b0, 3'b010, 32'd0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 2'b00, 4'b1111, 32'd0);

        chk("sb/drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit sitting directly downstream of the ALU in the execute/memory path. It takes the ALU `result` as the effective address and performs one RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW access over a valid/ready data-memory port. It handles byte-lane steering, alignment checking, load sign/zero extension and a response timeout. The unit is blocking: one transaction is in flight at a time.

## Interface
- `TIMEOUT_CYCLES`, default 1024: the maximum number of cycles spent in REQ+WAIT before the access is aborted. A value of 0 disables the timeout.

Ports:
- `clk` input 1: single clock; everything is sampled on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: the core presents an access.
- `req_ready` output 1: the LSU is in IDLE and not stale; the access is accepted when `req_valid & req_ready`.
- `req_addr` input 32: effective address (the ALU `result`).
- `req_we` input 1: 1 means store, 0 means load.
- `req_funct3` input 3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_wdata` input 32: store data (rs2).
- `mem_valid` output 1: memory request.
- `mem_ready` input 1: memory accepts the request.
- `mem_addr` output 32: word address, `{addr[31:2],2'b00}`.
- `mem_we` output 1: write enable.
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_rvalid` input 1: memory response (for both loads and stores).
- `mem_rdata` input 32: read word.
- `rsp_valid` output 1: one-cycle completion pulse; the consumer always accepts it.
- `rsp_data` output 32: extended load data; 0 for stores and for errors.
- `rsp_err` output 2: 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. `rst_n` low forces IDLE immediately and clears the stale flag.
- **IDLE**
  - `req_ready`=1.
  - On accept, decode the request:
    - funct3 011/110/111 → illegal (11).
    - Stores with funct3 1xx → illegal (11).
    - H/HU with `addr[0]`=1 → misaligned (01).
    - W with `addr[1:0]`≠0 → misaligned (01).
  - On any error: go to RESP with `rsp_err` set and issue no memory access.
  - Otherwise: latch the mem fields and go to REQ.
- **Byte lanes**
  - Let `off = addr[1:0]`.
  - B: `mem_be` = 0001<<off; `mem_wdata` = byte replicated ×4.
  - H: `mem_be` = 0011<<off; `mem_wdata` = halfword replicated ×2.
  - W: `mem_be` = 1111.
  - Loads drive `mem_be` the same way and `mem_we`=0.
- **REQ**
  - `mem_valid`=1.
  - `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are held stable until `mem_ready`.
  - On `mem_ready`, go to WAIT.
- **WAIT**
  - On `mem_rvalid`, capture data and go to RESP.
  - Load extraction: shift `mem_rdata` right by 8·off, then sign-extend (B, H) or zero-extend (BU, HU). W passes through unchanged.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle, then go to IDLE.
- **Timeout**
  - A counter clears on entry to REQ and increments every cycle spent in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES` (if nonzero), go to RESP with err 10 and `rsp_data`=0.
  - If the timeout occurred in WAIT, set the stale flag.
- **Stale flag**
  - While set, `req_ready`=0.
  - The next `mem_rvalid` is discarded and clears the flag.
- **Memory contract**
  - `mem_rvalid` arrives ≥1 cycle after the accepting `mem_ready`.
  - `mem_rvalid` outside WAIT (or outside stale draining) is ignored.

## Timing
- **Reset values**
  - `req_ready`=1.
  - `mem_valid`, `mem_we`, `rsp_valid`=0.
  - `mem_addr`, `mem_be`, `mem_wdata`, `rsp_data`=0.
  - `rsp_err`=00.
- All mem and rsp outputs come from registers or the state decode; there are no combinational paths from `req_*` inputs to `mem_*` outputs.
- **Best-case latency:** accept at cycle 0 → `mem_valid` at cycle 1 (`mem_ready`=1) → `mem_rvalid` at cycle 2 → `rsp_valid` at cycle 3.
- **Error latency:** accept at cycle 0 → `rsp_valid` at cycle 1.
- **Back-to-back:** the next accept can occur in the cycle after RESP, giving a minimum period of 4 cycles per access.
- **Reset mid-transaction:** `mem_valid` drops asynchronously and no `rsp_valid` is generated.
- **Simultaneous events:** a timeout on the same cycle as `mem_ready` (REQ) or `mem_rvalid` (WAIT) — the handshake wins and the timeout is not taken.

## Test plan
- **LB with sign extension:** `req_addr`=0x1003, `mem_rdata`=0x80AA_BBCC.
  - `mem_be`=1000.
  - `rsp_data`=0xFFFF_FF80 with err 00, 3 cycles after accept.
  - The same access as LBU gives 0x0000_0080.
- **SH to upper half:** `req_addr`=0x2002, `req_wdata`=0x1234_ABCD.
  - `mem_addr`=0x2000, `mem_be`=1100, `mem_wdata`=0xABCD_ABCD, `mem_we`=1.
  - `rsp_data`=0, err 00.
- **Misaligned and illegal requests:**
  - LW at 0x3001 → `rsp_err`=01 one cycle after accept, `mem_valid` never asserted.
  - funct3=011 → err 11.
  - SB with funct3=100 → err 11.
- **Backpressure:** `mem_ready` held low for 5 cycles.
  - `mem_valid` and all mem fields stay constant throughout.
  - `rsp_valid` appears 2 cycles after `mem_ready` rises (given `mem_rvalid` the cycle after).
- **Timeout and stale drain:** `TIMEOUT_CYCLES`=8, no `mem_rvalid`.
  - `rsp_err`=10 after 8 REQ+WAIT cycles.
  - `req_ready` stays 0 until a late `mem_rvalid` arrives; that data is dropped and `req_ready` returns to 1 the next cycle.
- **Reset mid-access:** `rst_n` pulled low while in WAIT.
  - Outputs reach reset values immediately.
  - A following `mem_rvalid` produces no `rsp_valid`.
  - A new LW completes normally.
